// File: rtl/dual_port_ram_clr.sv
// Two-port RAM with a power-up clear sweep. Every word is zeroed after reset
// before the ports are allowed to touch memory.
module dual_port_ram_clr #(
    parameter int DW      = 8,
    parameter int AW      = 6,
    parameter int RD_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] add0,
    input  logic [AW-1:0] add1,
    input  logic [DW-1:0] data0_in,
    input  logic [DW-1:0] data1_in,
    output logic [DW-1:0] data0_out,
    output logic [DW-1:0] data1_out,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          busy,
    output logic          collision
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] data0_q, data0_d;
    logic [DW-1:0] data1_q, data1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          collision_q, collision_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          we0_s, we1_s;
    logic [AW-1:0] wa0_s, wa1_s;
    logic [DW-1:0] wd0_s, wd1_s;
    logic [DW-1:0] rd0_s, rd1_s;
    logic          same_addr_s;

    // Read data per port, forwarding the other port's write data in write-first mode
    always_comb begin
        same_addr_s = (add0 == add1);
        if ((RD_MODE != 0) && !wr1 && same_addr_s) begin
            rd0_s = data1_in;
        end else begin
            rd0_s = mem_q[add0];
        end
        if ((RD_MODE != 0) && !wr0 && same_addr_s) begin
            rd1_s = data0_in;
        end else begin
            rd1_s = mem_q[add1];
        end
    end

    // Next-state, output and memory-write decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        collision_d = 1'b0;
        we0_s       = 1'b0;
        we1_s       = 1'b0;
        wa0_s       = add0;
        wa1_s       = add1;
        wd0_s       = data0_in;
        wd1_s       = data1_in;
        if (rst_n) begin
            case (state_q)
                ST_INIT: begin
                    we0_s = 1'b1;
                    wa0_s = cnt_q;
                    wd0_s = '0;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == {AW{1'b1}}) begin
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_INIT;
                        busy_d  = 1'b1;
                    end
                end
                ST_READY: begin
                    busy_d = 1'b0;
                    if (!en) begin
                        data0_d = '0;
                        data1_d = '0;
                    end else begin
                        if (!wr0) begin
                            we0_s = 1'b1;
                        end else begin
                            data0_d   = rd0_s;
                            rvalid0_d = 1'b1;
                        end
                        // Port 0 wins a dual-write clash; port 1's write is dropped
                        if (!wr1) begin
                            we1_s = !((!wr0) && same_addr_s);
                        end else begin
                            data1_d   = rd1_s;
                            rvalid1_d = 1'b1;
                        end
                        collision_d = (!wr0) && (!wr1) && same_addr_s;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end else begin
            we0_s = 1'b0;
            we1_s = 1'b0;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            data0_q     <= '0;
            data1_q     <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            collision_q <= collision_d;
        end
    end

    // Memory array; contents only change through the decoded write strobes
    always_ff @(posedge clk) begin
        if (we1_s) begin
            mem_q[wa1_s] <= wd1_s;
        end
        if (we0_s) begin
            mem_q[wa0_s] <= wd0_s;
        end
    end

    assign data0_out = data0_q;
    assign data1_out = data1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign busy      = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Self-checking bench for dual_port_ram_clr: directed vector table, reset/sweep
// sequences and randomized traffic against a behavioural memory model.
module tb_dual_port_ram_clr;

    localparam int DW      = 8;
    localparam int AW      = 6;
    localparam int RD_MODE = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr0, wr1;
    logic [AW-1:0] add0, add1;
    logic [DW-1:0] data0_in, data1_in;
    logic [DW-1:0] data0_out, data1_out;
    logic          rvalid0, rvalid1, busy, collision;

    always #5 clk = ~clk;

    dual_port_ram_clr #(.DW(DW), .AW(AW), .RD_MODE(RD_MODE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wr0       (wr0),
        .wr1       (wr1),
        .add0      (add0),
        .add1      (add1),
        .data0_in  (data0_in),
        .data1_in  (data1_in),
        .data0_out (data0_out),
        .data1_out (data1_out),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .busy      (busy),
        .collision (collision)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] mdl_mem [64];
    logic [DW-1:0] mdl_d0, mdl_d1;
    logic          mdl_rv0, mdl_rv1, mdl_col;

    typedef struct {
        logic          en, wr0, wr1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [DW-1:0] e_d0, e_d1;
        logic          e_rv0, e_rv1, e_col;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
        mdl_d0 = '0; mdl_d1 = '0;
        mdl_rv0 = 1'b0; mdl_rv1 = 1'b0; mdl_col = 1'b0;
    endtask

    // Expected effect of one READY-state edge, stated from the port rules
    task automatic model_edge();
        logic [DW-1:0] old0, old1;
        old0 = mdl_mem[add0];
        old1 = mdl_mem[add1];
        mdl_rv0 = 1'b0; mdl_rv1 = 1'b0; mdl_col = 1'b0;
        if (!en) begin
            mdl_d0 = '0; mdl_d1 = '0;
        end else begin
            if (wr0) begin
                mdl_rv0 = 1'b1;
                mdl_d0  = (RD_MODE == 1 && !wr1 && add1 == add0) ? data1_in : old0;
            end
            if (wr1) begin
                mdl_rv1 = 1'b1;
                mdl_d1  = (RD_MODE == 1 && !wr0 && add0 == add1) ? data0_in : old1;
            end
            mdl_col = (!wr0 && !wr1 && add0 == add1);
            if (!wr1) mdl_mem[add1] = data1_in;
            if (!wr0) mdl_mem[add0] = data0_in;
        end
    endtask

    task automatic apply(input logic e, input logic w0, input logic w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        en = e; wr0 = w0; wr1 = w1; add0 = a0; add1 = a1; data0_in = d0; data1_in = d1;
        model_edge();
        step();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_d0"},  data0_out, mdl_d0);
        check({tag, "_d1"},  data1_out, mdl_d1);
        check({tag, "_rv0"}, rvalid0,   mdl_rv0);
        check({tag, "_rv1"}, rvalid1,   mdl_rv1);
        check({tag, "_col"}, collision, mdl_col);
        check({tag, "_busy"}, busy,     1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_d0"}, data0_out, 8'h00);
        check({tag, "_d1"}, data1_out, 8'h00);
        check({tag, "_rv"}, {rvalid0, rvalid1, collision}, 3'b000);
    endtask

    // Release reset and count busy cycles while hammering the ports
    task automatic run_sweep(input string tag);
        int  n;
        bit  loud;
        n = 0; loud = 1'b0;
        rst_n = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            en = 1'b1; wr0 = $urandom_range(0, 1); wr1 = $urandom_range(0, 1);
            add0 = AW'($urandom_range(0, 63)); add1 = AW'($urandom_range(0, 63));
            data0_in = 8'hFF; data1_in = 8'hEE;
            n++;
            step();
            if (busy === 1'b1 && (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || collision !== 1'b0)) loud = 1'b1;
        end
        check({tag, "_sweep_len"}, n, 64);
        check({tag, "_sweep_quiet"}, loud, 1'b0);
        model_clear();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr0 = 1'b1; wr1 = 1'b1;
        add0 = '0; add1 = '0; data0_in = '0; data1_in = '0;
        model_clear();

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 6'd12, 6'd0,  8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 6'd12, 6'd12, 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd5,  6'd5,  8'h11, 8'h22, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd5,  6'd7,  8'h00, 8'h3C, 8'h11, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 6'd7,  6'd7,  8'h99, 8'h00, 8'h11, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 6'd7,  6'd7,  8'h00, 8'h00, 8'h99, 8'h99, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'd12, 6'd13, 8'h55, 8'h66, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 6'd12, 6'd13, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd20, 6'd21, 8'h01, 8'h02, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 6'd20, 6'd21, 8'h00, 8'h00, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 6'd63, 6'd63, 8'h7E, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 6'd63, 6'd0,  8'h00, 8'h00, 8'h7E, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4].e_d1  = (RD_MODE != 0) ? 8'h99 : 8'h3C;
        vecs[10].e_d1 = (RD_MODE != 0) ? 8'h7E : 8'h00;

        // Reset held low with port activity: outputs forced, no sweep progress
        repeat (3) begin
            en = 1'b1; wr0 = 1'b0; wr1 = 1'b1; add0 = 6'd12; data0_in = 8'hC3;
            step();
        end
        check_reset_outputs("reset");
        run_sweep("por");

        // Fresh memory reads back zero on both ports, one cycle later
        apply(1'b1, 1'b1, 1'b1, 6'd33, 6'd63, 8'h00, 8'h00);
        check("clear_rd_d0", data0_out, 8'h00);
        check("clear_rd_d1", data1_out, 8'h00);
        check("clear_rd_rv", {rvalid0, rvalid1}, 2'b11);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].en, vecs[i].wr0, vecs[i].wr1, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            check($sformatf("vec%0d_d0", i),  data0_out, vecs[i].e_d0);
            check($sformatf("vec%0d_d1", i),  data1_out, vecs[i].e_d1);
            check($sformatf("vec%0d_rv0", i), rvalid0,   vecs[i].e_rv0);
            check($sformatf("vec%0d_rv1", i), rvalid1,   vecs[i].e_rv1);
            check($sformatf("vec%0d_col", i), collision, vecs[i].e_col);
        end

        // Randomized traffic with frequent address clashes
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a0, a1;
            a0 = AW'($urandom_range(0, 63));
            a1 = ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom_range(0, 63));
            apply(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a0, a1, 8'($urandom), 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // A read requested in the reset cycle is discarded
        en = 1'b1; wr0 = 1'b1; wr1 = 1'b1; add0 = 6'd20; add1 = 6'd21;
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_op_reset");
        run_sweep("after_op_reset");

        // Write 0xFF to 40, then reset, abort the sweep at cycle 30 and restart
        apply(1'b1, 1'b0, 1'b1, 6'd40, 6'd40, 8'hFF, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b1; wr0 = 1'b0; wr1 = 1'b0; add0 = 6'd40; add1 = 6'd41; data0_in = 8'hFF; data1_in = 8'hFF;
        repeat (30) step();
        check("part_sweep_busy", busy, 1'b1);
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_sweep_reset");
        run_sweep("restart");
        apply(1'b1, 1'b1, 1'b1, 6'd40, 6'd41, 8'h00, 8'h00);
        check("addr40_d0", data0_out, 8'h00);
        check("addr41_d1", data1_out, 8'h00);
        check("addr40_rv", {rvalid0, rvalid1}, 2'b11);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_clr.md
DUAL_PORT_RAM_CLR -- requirements
Module: dual_port_ram_clr

Interface
REQ-001: Parameter DW, default 8, data width in bits.
REQ-002: Parameter AW, default 6, address width; depth = 2^AW words.
REQ-003: Parameter RD_MODE, default 0, same-address read/write policy: 0 = read-first (old data), 1 = write-first (new data).
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: rst_n  input  1  reset, synchronous, active-low.
REQ-006: en  input  1  global enable; 0 clears both data outputs.
REQ-007: wr0 / wr1  input  1  per-port mode, active-low: 0 = write, 1 = read.
REQ-008: add0 / add1  input  AW  per-port word address.
REQ-009: data0_in / data1_in  input  DW  per-port write data.
REQ-010: data0_out / data1_out  output  DW  per-port registered read data.
REQ-011: rvalid0 / rvalid1  output  1  per-port pulse, high the cycle after an accepted read.
REQ-012: busy  output  1  high while the memory-clear sweep runs.
REQ-013: collision  output  1  one-cycle pulse on a dual-write address clash.

Function
REQ-014: Two states SHALL exist: INIT (clear sweep) and READY.
REQ-015: INIT: each cycle the block SHALL write 0 to mem[cnt] and increment the AW-bit counter cnt; after writing address 2^AW-1 it SHALL enter READY on the next edge (sweep = exactly 2^AW cycles).
REQ-016: busy SHALL be 1 in INIT and 0 in READY; port inputs SHALL be ignored in INIT; rvalid0/1 and collision SHALL stay 0.
REQ-017: READY, en=0: data0_out, data1_out, rvalid0, rvalid1 and collision SHALL be 0 after the next edge; no memory write.
REQ-018: READY, en=1, wrN=0: mem[addN] <= dataN_in at the edge; dataN_out holds its value; rvalidN <= 0.
REQ-019: READY, en=1, wrN=1: dataN_out <= mem[addN] at the edge (latency 1 cycle); rvalidN <= 1.
REQ-020: Both ports write the same address: port 0 data SHALL be stored; collision SHALL be 1 for exactly the following cycle.
REQ-021: One port writes and the other reads the same address: the reader SHALL return old contents if RD_MODE=0 and the written data if RD_MODE=1; collision SHALL stay 0.
REQ-022: Both ports read the same address: both SHALL return identical data; collision SHALL stay 0.
REQ-023: Different addresses: the ports SHALL operate fully independently in the same cycle.
REQ-024: Addresses SHALL be used unmodified (no wrap or range check needed; AW covers the full depth).

Reset
REQ-025: rst_n=0 at an edge SHALL force state INIT, cnt=0, busy=1, all data outputs 0, rvalid0/1=0, collision=0.
REQ-026: Memory contents SHALL become all-zero only via the INIT sweep, not in the reset cycle itself.
REQ-027: rst_n asserted mid-sweep or mid-operation SHALL restart the sweep from address 0; pending reads SHALL be discarded (no rvalid).
REQ-028: While rst_n is held low, cnt SHALL stay 0 and no memory write SHALL occur.

Verification (AW=6, DW=8)
REQ-029: Release rst_n -> busy=1 for exactly 64 cycles, then 0; reading any address returns 8'h00 with rvalid=1 one cycle after the request.
REQ-030: Port0 writes 8'hA5 to 12, next cycle port1 reads 12 -> data1_out=8'hA5, rvalid1=1 one cycle later.
REQ-031: Same cycle: port0 writes 8'h11 and port1 writes 8'h22 to address 5 -> collision=1 for one cycle; later read of 5 returns 8'h11.
REQ-032: mem[7]=8'h3C; same cycle port0 writes 8'h99 to 7 while port1 reads 7 -> data1_out=8'h3C (RD_MODE=0) or 8'h99 (RD_MODE=1).
REQ-033: Read in progress, then en=0 for one cycle -> data0_out=data1_out=0, rvalid0=rvalid1=0, memory unchanged on re-read.
REQ-034: Assert rst_n=0 at sweep cycle 30 after writing 8'hFF to address 40 -> sweep restarts, busy high 64 more cycles, address 40 reads 8'h00.
